uart_tx_buffered: RTL

UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

---
 rtl/uart_pkg.sv | 8 +
 rtl/sync_fifo.sv | 56 +++++
 rtl/uart_tx_buffered.sv | 127 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states and 8N1 frame constants.
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;

  localparam int   DATA_BITS = 8;
  localparam int   STOP_BITS = 1;
  localparam logic LINE_IDLE = 1'b1;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; full/empty come from the count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rptr_q];
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end
endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: FIFO in front of a start/data/stop serialiser.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 5208,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    TX_DATA,
  input  logic                          TX_EN,
  output logic                          TX_READY,
  output logic                          TX_STATUS,
  output logic [$clog2(FIFO_DEPTH):0]   TX_COUNT,
  output logic                          OVERFLOW,
  output logic                          UART_TXD
);
  localparam int            TW       = $clog2(CLK_DIV);
  localparam int            BW       = $clog2(DATA_BITS);
  localparam logic [TW-1:0] BIT_LAST = TW'(CLK_DIV - 1);

  tx_state_e              state_q, state_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [BW-1:0]          bidx_q, bidx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   txd_q, txd_d;
  logic                   ovf_q;
  logic                   pop, full, empty, expire;
  logic [DATA_BITS-1:0]   head;

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (TX_EN & reset),
    .wdata (TX_DATA),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (TX_COUNT)
  );

  assign expire    = (timer_q == '0);
  assign TX_READY  = ~full;
  assign TX_STATUS = (state_q == IDLE) & empty;
  assign OVERFLOW  = ovf_q;
  assign UART_TXD  = txd_q;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    bidx_d  = bidx_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        bidx_d  = '0;
        if (!empty) begin
          state_d = START;
          pop     = 1'b1;
          shift_d = head;
          timer_d = BIT_LAST;
        end
      end
      START: begin
        if (expire) begin
          state_d = DATA;
          timer_d = BIT_LAST;
        end else timer_d = timer_q - 1'b1;
      end
      DATA: begin
        if (expire) begin
          timer_d = BIT_LAST;
          shift_d = shift_q >> 1;
          if (bidx_q == BW'(DATA_BITS - 1)) begin
            state_d = STOP;
            bidx_d  = '0;
          end else bidx_d = bidx_q + 1'b1;
        end else timer_d = timer_q - 1'b1;
      end
      STOP: begin
        // Chaining straight into START keeps back-to-back frames gap-free.
        if (expire) begin
          if (!empty) begin
            state_d = START;
            pop     = 1'b1;
            shift_d = head;
            timer_d = BIT_LAST;
          end else begin
            state_d = IDLE;
            timer_d = '0;
          end
        end else timer_d = timer_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // The line follows the state one cycle late, so each bit still lasts CLK_DIV cycles.
  always_comb begin
    txd_d = LINE_IDLE;
    case (state_q)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_q[0];
      default: txd_d = LINE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      bidx_q  <= '0;
      shift_q <= '0;
      txd_q   <= LINE_IDLE;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bidx_q  <= bidx_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      if (TX_EN && full) ovf_q <= 1'b1;
    end
  end
endmodule
